// File: rtl/core_seq.sv
// Multi-cycle sequencer around the RV32I control/decode unit: owns PC, IR and load latch,
// arbitrates one memory bus. Optional ack watchdog enabled by defining CORE_SEQ_TIMEOUT_EN.
module core_seq #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    input  logic [31:0] pc_next_in,
    input  logic        reg_wr_en_in,
    output logic        reg_wr_en_out,
    input  logic [31:0] dmem_rd_addr_in,
    input  logic        dmem_wr_en_in,
    input  logic [31:0] dmem_wr_addr_in,
    input  logic [31:0] dmem_wr_data_in,
    output logic [31:0] dmem_rd_data_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    // state   | meaning
    // S_FETCH | bus read at pc, wait for ack, capture IR
    // S_EXEC  | one cycle for the control unit to settle on IR
    // S_MEM   | load/store bus transfer, wait for ack
    // S_WB    | commit: register write, pc update, retire count
    // S_HALT  | stopped (SYSTEM opcode, misaligned target or timeout)
    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ld_data;
    logic        timeout_hit;
    logic        target_ok;

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0] wait_cnt;

    // Counter is zero outside bus states, so it is already clear on every FETCH/MEM entry.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wait_cnt <= '0;
        end else if (mem_req && !mem_ack && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_hit = mem_req && !mem_ack && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    assign target_ok = (pc_next_in[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= 32'h0000_0013;
            ld_data <= 32'h0;
            fault   <= 1'b0;
            retired <= 32'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        state <= S_EXEC;
                    end else if (timeout_hit) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (ir[6:0] == OP_SYSTEM) begin
                        state <= S_HALT;
                    end else if (ir[6:0] == OP_LOAD || ir[6:0] == OP_STORE) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (ir[6:0] == OP_LOAD) begin
                            ld_data <= mem_rdata;
                        end
                        state <= S_WB;
                    end else if (timeout_hit) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end
                end
                S_WB: begin
                    if (!target_ok) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        pc      <= pc_next_in;
                        retired <= retired + 32'd1;
                        state   <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = dmem_wr_en_in;
                mem_addr  = dmem_wr_en_in ? dmem_wr_addr_in : dmem_rd_addr_in;
                mem_wdata = dmem_wr_data_in;
            end
            default: ;
        endcase
    end

    assign reg_wr_en_out    = (state == S_WB) && reg_wr_en_in && target_ok;
    assign halted           = (state == S_HALT);
    assign pc_out           = pc;
    assign instr_out        = ir;
    assign dmem_rd_data_out = ld_data;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: reset, ALU/load/store commits, SYSTEM halt,
// misaligned target, mid-fetch reset and (with CORE_SEQ_TIMEOUT_EN) the ack watchdog.
module tb_core_seq;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [31:0] pc_next_in;
    logic        reg_wr_en_in;
    logic        reg_wr_en_out;
    logic [31:0] dmem_rd_addr_in;
    logic        dmem_wr_en_in;
    logic [31:0] dmem_wr_addr_in;
    logic [31:0] dmem_wr_data_in;
    logic [31:0] dmem_rd_data_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_LW   = 32'h1000_2083;
    localparam logic [31:0] I_SW   = 32'h2020_2223;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;

    core_seq dut (
        .clk              (clk),
        .nrst             (nrst),
        .pc_out           (pc_out),
        .instr_out        (instr_out),
        .pc_next_in       (pc_next_in),
        .reg_wr_en_in     (reg_wr_en_in),
        .reg_wr_en_out    (reg_wr_en_out),
        .dmem_rd_addr_in  (dmem_rd_addr_in),
        .dmem_wr_en_in    (dmem_wr_en_in),
        .dmem_wr_addr_in  (dmem_wr_addr_in),
        .dmem_wr_data_in  (dmem_wr_data_in),
        .dmem_rd_data_out (dmem_rd_data_out),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack),
        .halted           (halted),
        .fault            (fault),
        .retired          (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge, checks follow a further 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        nrst    = 1'b0;
        mem_ack = 1'b0;
        repeat (3) tick();
        nrst = 1'b1;
        settle();
    endtask

    // From FETCH with zero-wait ack, run an ALU instruction through to the next FETCH.
    task automatic run_alu(input logic [31:0] next_pc);
        mem_ack = 1'b1; mem_rdata = I_ADDI;
        tick();
        mem_ack = 1'b0; pc_next_in = next_pc; reg_wr_en_in = 1'b1;
        tick();
        tick();
        settle();
    endtask

    initial begin
        nrst = 1'b0; pc_next_in = 32'h0; reg_wr_en_in = 1'b0;
        dmem_rd_addr_in = 32'h0; dmem_wr_en_in = 1'b0; dmem_wr_addr_in = 32'h0;
        dmem_wr_data_in = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;

        do_reset();
        check("rst_mem_req", 32'(mem_req), 32'd1);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_reg_wr", 32'(reg_wr_en_out), 32'd0);
        check("rst_ir_nop", instr_out, 32'h0000_0013);
        check("rst_halt_fault", {30'h0, halted, fault}, 32'h0);

        // ADDI, zero-wait
        mem_ack = 1'b1; mem_rdata = I_ADDI; pc_next_in = 32'h4; reg_wr_en_in = 1'b1;
        settle();
        check("addi_c1_we", {30'h0, mem_we, reg_wr_en_out}, 32'h0);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        settle();
        check("addi_c2_ir", instr_out, I_ADDI);
        check("addi_c2_req_wr", {30'h0, mem_req, reg_wr_en_out}, 32'h0);
        tick(); settle();
        check("addi_c3_wr", 32'(reg_wr_en_out), 32'd1);
        check("addi_c3_pc", pc_out, 32'h0);
        tick(); settle();
        check("addi_c4_wr", 32'(reg_wr_en_out), 32'd0);
        check("addi_pc", pc_out, 32'h4);
        check("addi_retired", retired, 32'd1);
        check("addi_fetch_addr", mem_addr, 32'h4);

        // LW with two wait cycles in MEM
        mem_ack = 1'b1; mem_rdata = I_LW;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
        dmem_rd_addr_in = 32'h100; dmem_wr_en_in = 1'b0; pc_next_in = 32'h8; reg_wr_en_in = 1'b1;
        settle();
        check("lw_exec_req", 32'(mem_req), 32'd0);
        for (int w = 0; w < 2; w++) begin
            tick(); settle();
            check("lw_mem_addr", mem_addr, 32'h100);
            check("lw_mem_req_we", {30'h0, mem_req, mem_we}, 32'h2);
            check("lw_no_capture", dmem_rd_data_out, 32'h0);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        check("lw_ack_addr", mem_addr, 32'h100);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        settle();
        check("lw_wb_data", dmem_rd_data_out, 32'hDEAD_BEEF);
        check("lw_wb_wr", 32'(reg_wr_en_out), 32'd1);
        tick(); settle();
        check("lw_pc", pc_out, 32'h8);
        check("lw_retired", retired, 32'd2);

        // SW with one wait cycle
        mem_ack = 1'b1; mem_rdata = I_SW;
        tick();
        mem_ack = 1'b0;
        dmem_wr_en_in = 1'b1; dmem_wr_addr_in = 32'h204; dmem_wr_data_in = 32'h1234_5678;
        pc_next_in = 32'hC; reg_wr_en_in = 1'b0;
        settle();
        check("sw_exec_idle", {mem_wdata[30:0], mem_we}, 32'h0);
        for (int w = 0; w < 2; w++) begin
            tick();
            mem_ack = (w == 1);
            settle();
            check("sw_mem_we", 32'(mem_we), 32'd1);
            check("sw_mem_addr", mem_addr, 32'h204);
            check("sw_mem_wdata", mem_wdata, 32'h1234_5678);
        end
        tick();
        mem_ack = 1'b0;
        settle();
        check("sw_wb_idle", {mem_wdata[30:0], mem_we}, 32'h0);
        check("sw_wb_wr", 32'(reg_wr_en_out), 32'd0);
        tick(); settle();
        check("sw_fetch_we", 32'(mem_we), 32'd0);
        check("sw_pc", pc_out, 32'hC);
        check("sw_retired", retired, 32'd3);
        dmem_wr_en_in = 1'b0;

        // Misaligned target halts without commit
        mem_ack = 1'b1; mem_rdata = I_ADDI;
        tick();
        mem_ack = 1'b0; pc_next_in = 32'h6; reg_wr_en_in = 1'b1;
        tick(); settle();
        check("mis_wb_wr", 32'(reg_wr_en_out), 32'd0);
        tick();
        mem_ack = 1'b1;
        settle();
        check("mis_halt_fault", {30'h0, halted, fault}, 32'h3);
        check("mis_pc", pc_out, 32'hC);
        check("mis_retired", retired, 32'd3);
        repeat (3) tick();
        check("mis_stays", {29'h0, mem_req, halted, fault}, 32'h3);

        // SYSTEM opcode halts cleanly
        do_reset();
        mem_ack = 1'b1; mem_rdata = I_ECALL;
        tick();
        mem_ack = 1'b0;
        tick(); settle();
        check("ecall_halt", {29'h0, mem_req, halted, fault}, 32'h2);
        check("ecall_retired", retired, 32'd0);

        // Reset during a stalled fetch, ack arriving at the reset edge
        do_reset();
        run_alu(32'h4);
        check("mid_pre_pc", pc_out, 32'h4);
        tick(); tick();
        nrst = 1'b0; mem_ack = 1'b1; mem_rdata = I_LW;
        tick();
        nrst = 1'b1; mem_ack = 1'b0;
        settle();
        check("mid_pc", pc_out, 32'h0);
        check("mid_ir", instr_out, 32'h0000_0013);
        check("mid_retired", retired, 32'd0);
        check("mid_fetch", {30'h0, mem_req, halted}, 32'h2);

`ifdef CORE_SEQ_TIMEOUT_EN
        do_reset();
        repeat (254) tick();
        check("to_not_yet", {30'h0, halted, fault}, 32'h0);
        tick();
        check("to_halt_fault", {29'h0, mem_req, halted, fault}, 32'h3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multi-cycle sequencer for the RV32I combinational control/decode unit.
- Owns PC, instruction register (IR) and load-data latch.
- Shares one memory bus between instruction fetch and data load/store.
- Gates register-file write and PC update so each instruction commits exactly once.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with CORE_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- pc_out  out  32  current PC to control unit.
- instr_out  out  32  latched IR to control unit.
- pc_next_in  in  32  next PC computed by control unit.
- reg_wr_en_in  in  1  register write request from control unit.
- reg_wr_en_out  out  1  gated register-file write enable.
- dmem_rd_addr_in  in  32  load address from control unit.
- dmem_wr_en_in  in  1  store flag from control unit.
- dmem_wr_addr_in  in  32  store address from control unit.
- dmem_wr_data_in  in  32  store data from control unit.
- dmem_rd_data_out  out  32  latched load word to control unit.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_rdata  in  32  bus read data, valid with mem_ack.
- mem_ack  in  1  transfer complete; may be high in the same cycle as mem_req.
- halted  out  1  core stopped.
- fault  out  1  misaligned PC target, or bus timeout.
- retired  out  32  count of instructions committed.

Behaviour:
Clock, reset and reset values:
- Single clock domain. nrst is synchronous, active-low.
- Reset values: state=FETCH; pc=RESET_PC; IR=32'h0000_0013 (NOP); dmem_rd_data_out=0; reg_wr_en_out=0; halted=0; fault=0; retired=0.
- mem_req is combinational from state, so it is 1 in the first cycle after reset.
- Reset asserted mid-transfer: at that edge the block returns to FETCH with reset values. A late mem_ack for the aborted transfer is ignored, i.e. any ack not in FETCH/MEM is ignored.

States:
- FETCH: mem_req=1, mem_we=0, mem_addr=pc.
  - Outputs held stable until mem_ack.
  - On ack: IR<=mem_rdata, go to EXEC.
- EXEC: exactly one cycle; mem_req=0; control unit settles on IR.
  - IR[6:0]=7'b1110011 (SYSTEM) -> HALT.
  - IR[6:0]=7'b0000011 (LOAD) or 7'b0100011 (STORE) -> MEM.
  - Any other opcode -> WB.
- MEM: mem_req=1; mem_we=dmem_wr_en_in.
  - mem_addr = dmem_wr_addr_in if store, else dmem_rd_addr_in.
  - mem_wdata=dmem_wr_data_in.
  - On ack: for loads, dmem_rd_data_out<=mem_rdata; go to WB.
- WB: one cycle.
  - If pc_next_in[1:0]!=0: fault<=1, no register write, pc unchanged, go to HALT.
  - Otherwise: reg_wr_en_out=reg_wr_en_in (combinational, this cycle only); pc<=pc_next_in; retired<=retired+1 (wraps at 2^32); go to FETCH.
- HALT: halted=1, mem_req=0, reg_wr_en_out=0. Exit only by reset.

Output rules:
- reg_wr_en_out is 0 in every state except WB.
- mem_wdata is 0 and mem_we is 0 whenever mem_req=0.
- IR and dmem_rd_data_out stay stable from capture through WB, so control-unit outputs are stable in WB.

Timing:
- Latency with zero-wait bus (ack in the same cycle as req): ALU/jump/branch = 3 cycles (FETCH, EXEC, WB); load/store = 4 cycles.

Optional Feature:
- Macro: CORE_SEQ_TIMEOUT_EN.
- With macro defined:
  - An 8+ bit counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && mem_ack=0.
  - When the count reaches TIMEOUT_CYCLES: fault<=1, go to HALT, mem_req drops next cycle, no commit.
- Without macro: waits indefinitely for mem_ack; fault is set only by misaligned PC.

Test Plan:
- Reset check: hold nrst=0 3 cycles, release -> mem_req=1, mem_addr=0, retired=0, reg_wr_en_out=0.
- ADDI, zero-wait bus: ack immediately with 32'h00500093, pc_next_in=4, reg_wr_en_in=1 -> reg_wr_en_out high exactly 1 cycle in cycle 3; pc_out=4; retired=1.
- LW with 2-wait ack: dmem_rd_addr_in=32'h100, mem_rdata=32'hDEADBEEF -> MEM has mem_addr=32'h100, mem_we=0; dmem_rd_data_out=32'hDEADBEEF in WB; total 6 cycles.
- SW: dmem_wr_en_in=1, dmem_wr_addr_in=32'h204, dmem_wr_data_in=32'h12345678 -> mem_we=1 with those values until ack; mem_we=0 after.
- Misaligned target: pc_next_in=32'h6 -> fault=1, halted=1, pc_out unchanged, no reg write.
- Timeout and mid-transfer reset:
  - With CORE_SEQ_TIMEOUT_EN: withhold ack 255 cycles -> fault=1, halted=1.
  - Reset mid-FETCH, then late ack -> ignored, state=FETCH, pc=RESET_PC.
